// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a status register
// Ports: clk, resetn (async, active-low);
//        d_addr/dw_data/dw_size/rd_en: core data-memory port (store size 00 = no store);
//        d_data/sel_q: load data and read-mux select, one cycle after the load;
//        tx: serial line, idle high.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [13:0] BASE       = 14'h3FF0,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] d_addr,
    input  logic [31:0] dw_data,
    input  logic [1:0]  dw_size,
    input  logic        rd_en,
    output logic [31:0] d_data,
    output logic        sel_q,
    output logic        tx
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    localparam logic   PAR_FLAG   = 1'b1;
`else
    localparam state_t AFTER_DATA = STOP;
    localparam logic   PAR_FLAG   = 1'b0;
`endif
    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   baud;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shift, shift_n;
    logic          hit, store, push_req, push, pop, full, empty, clr, ovf;
    logic          baud_done, reload, tx_n;
    logic [31:0]   status;
    logic          unused_bits;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          par;
`endif

    assign hit       = d_addr[13:4] == BASE[13:4];
    assign store     = hit && dw_size != 2'b00;
    assign push_req  = store && d_addr[3:2] == 2'd0;
    assign clr       = store && d_addr[3:2] == 2'd1 && dw_data[3];
    // full/empty come from the pre-edge count, so a same-cycle pop never frees room for a push
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign push      = push_req && !full;
    assign baud_done = baud == '0;
    assign status    = {16'd0, 8'(count), 3'd0, PAR_FLAG, ovf, state != IDLE, empty, full};
    assign unused_bits = ^{dw_data[31:8], d_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        shift_n  = shift;
        bitcnt_n = bitcnt;
        case (state)
            IDLE:  if (!empty) begin
                       pop     = 1'b1;
                       state_n = START;
                   end
            START: if (baud_done) begin
                       state_n  = DATA;
                       bitcnt_n = 3'd0;
                   end
            DATA:  if (baud_done) begin
                       state_n  = bitcnt == 3'd7 ? AFTER_DATA : DATA;
                       bitcnt_n = bitcnt + 3'd1;
                       shift_n  = bitcnt == 3'd7 ? shift : shift >> 1;
                   end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: if (baud_done) state_n = STOP;
`endif
            STOP:  if (baud_done) begin
                       pop     = !empty;
                       state_n = empty ? IDLE : START;
                   end
            default: state_n = IDLE;
        endcase
        if (pop) shift_n = mem[rd_ptr];
        // every bit period starts a fresh countdown; the counter rests at 0 in IDLE
        reload = pop || (baud_done && state_n != IDLE);
        // tx is registered from the next state so the line changes exactly on the edge
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
        if (state_n == PARITY) tx_n = par;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dw_data[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            baud   <= '0;
            bitcnt <= '0;
            shift  <= '0;
            ovf    <= 1'b0;
            tx     <= 1'b1;
            sel_q  <= 1'b0;
            d_data <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            baud   <= reload ? DIV_M1 : baud_done ? baud : baud - 16'd1;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
            ovf    <= (push_req && full) || (ovf && !clr);
            tx     <= tx_n;
            sel_q  <= rd_en && hit;
            if (rd_en && hit) d_data <= d_addr[3:2] == 2'd1 ? status : 32'd0;
`ifdef MMIO_UART_TX_PARITY_EN
            if (pop) par <= ^mem[rd_ptr];
`endif
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx (frame-timeline reference model)
module tb_mmio_uart_tx;
    localparam int DIV   = 4;
    localparam int DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PARW  = 32'h10;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PARW  = 32'h0;
`endif
    localparam int          FL      = NBITS * DIV;
    localparam logic [31:0] IDLE_ST = 32'h2 | PARW;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [13:0] d_addr = '0;
    logic [31:0] dw_data = '0;
    logic [1:0]  dw_size = '0;
    logic        rd_en = 1'b0;
    logic [31:0] d_data;
    logic        sel_q;
    logic        tx;

    mmio_uart_tx #(.BASE(14'h3FF0), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .d_addr(d_addr), .dw_data(dw_data),
        .dw_size(dw_size), .rd_en(rd_en), .d_data(d_data), .sel_q(sel_q), .tx(tx)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted byte becomes a frame with a start edge; the line,
    // FIFO occupancy and busy flag at any edge follow from that timeline alone.
    typedef struct { logic [7:0] b; int push; int start; } frame_t;
    frame_t      frames[$];
    int          last_end = 0;
    logic        ovf_m = 1'b0;
    logic [31:0] exp_d = '0;
    logic        exp_sel = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        tx_hist [8192];

    function automatic int in_fifo(int e);
        int n = 0;
        foreach (frames[i]) if (frames[i].push <= e && frames[i].start > e) n++;
        return n;
    endfunction

    function automatic logic busy_at(int e);
        foreach (frames[i]) if (frames[i].start <= e && e < frames[i].start + FL) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic frame_bit(logic [7:0] b, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef MMIO_UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic tx_at(int e);
        foreach (frames[i])
            if (frames[i].start <= e && e < frames[i].start + FL)
                return frame_bit(frames[i].b, (e - frames[i].start) / DIV);
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_at(int e);
        int n = in_fifo(e);
        logic [31:0] s = PARW;
        s[0] = n == DEPTH;
        s[1] = n == 0;
        s[2] = busy_at(e);
        s[3] = ovf_m;
        s[15:8] = 8'(n);
        return s;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        frames.delete();
        last_end = 0;
        ovf_m = 1'b0;
        exp_d = '0;
        exp_sel = 1'b0;
    endtask

    task automatic tick();
        logic [31:0] st;
        logic hitm;
        int n, s;
        st = status_at(cyc);
        n = in_fifo(cyc);
        hitm = d_addr[13:4] == 10'h3FF;
        @(posedge clk);
        cyc++;
        if (!resetn) begin
            exp_d = '0;
            exp_sel = 1'b0;
        end else begin
            if (hitm && dw_size != 2'b00) begin
                if (d_addr[3:2] == 2'd0) begin
                    if (n < DEPTH) begin
                        s = (cyc + 1 > last_end) ? cyc + 1 : last_end;
                        frames.push_back('{dw_data[7:0], cyc, s});
                        last_end = s + FL;
                    end else ovf_m = 1'b1;
                end else if (d_addr[3:2] == 2'd1 && dw_data[3]) ovf_m = 1'b0;
            end
            exp_sel = rd_en && hitm;
            if (exp_sel) exp_d = d_addr[3:2] == 2'd1 ? st : 32'd0;
        end
        #1;
        if (cyc < 8192) tx_hist[cyc] = tx;
        check("tx", 32'(tx), 32'(tx_at(cyc)));
        check("sel_q", 32'(sel_q), 32'(exp_sel));
        check("d_data", d_data, exp_d);
    endtask

    task automatic drive(logic [13:0] a, logic [1:0] sz, logic [31:0] dat, logic rd);
        d_addr = a;
        dw_size = sz;
        dw_data = dat;
        rd_en = rd;
        tick();
        dw_size = 2'b00;
        rd_en = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) drive(14'h0, 2'b00, 32'h0, 1'b0);
    endtask

    // last frame of a burst pushed at edge p: busy through edge p+nf*FL, idle one edge later
    task automatic expect_drain(int p, int nf);
        while (cyc < p + nf * FL) idle(1);
        drive(14'h3FF4, 2'b00, 32'h0, 1'b1);
        check("busy_before_end", 32'(d_data[2]), 32'h1);
        drive(14'h3FF4, 2'b00, 32'h0, 1'b1);
        check("status_after_end", d_data, IDLE_ST);
    endtask

    typedef struct {
        logic [13:0] addr;
        logic [1:0]  size;
        logic [7:0]  data;
        logic        rd;
        logic        exp_sel;
        logic [31:0] exp_d;
    } vec_t;
    vec_t vt [13];

    initial begin
        int p;
        logic [9:0] pat;
        vt[0]  = '{14'h3FF4, 2'b00, 8'h00, 1'b1, 1'b1, IDLE_ST};
        vt[1]  = '{14'h3FF0, 2'b00, 8'h00, 1'b1, 1'b1, 32'h0};
        vt[2]  = '{14'h0000, 2'b00, 8'h00, 1'b1, 1'b0, 32'h0};
        vt[3]  = '{14'h3FF5, 2'b00, 8'h00, 1'b1, 1'b1, IDLE_ST};
        vt[4]  = '{14'h3FF4, 2'b00, 8'h00, 1'b0, 1'b0, IDLE_ST};
        vt[5]  = '{14'h3FF8, 2'b11, 8'hFF, 1'b1, 1'b1, 32'h0};
        vt[6]  = '{14'h3FF4, 2'b00, 8'h00, 1'b1, 1'b1, IDLE_ST};
        vt[7]  = '{14'h0000, 2'b01, 8'h55, 1'b0, 1'b0, IDLE_ST};
        vt[8]  = '{14'h3FFC, 2'b10, 8'h12, 1'b1, 1'b1, 32'h0};
        vt[9]  = '{14'h3FF4, 2'b00, 8'h00, 1'b1, 1'b1, IDLE_ST};
        vt[10] = '{14'h3FF0, 2'b00, 8'hAA, 1'b0, 1'b0, IDLE_ST};
        vt[11] = '{14'h1FF4, 2'b00, 8'h00, 1'b1, 1'b0, IDLE_ST};
        vt[12] = '{14'h3FF6, 2'b00, 8'h00, 1'b1, 1'b1, IDLE_ST};

        // reset values while reset is held
        #1 resetn = 1'b0;
        model_reset();
        #2;
        check("reset_tx", 32'(tx), 32'h1);
        check("reset_d_data", d_data, 32'h0);
        check("reset_sel_q", 32'(sel_q), 32'h0);
        tick();
        tick();
        resetn = 1'b1;

        // load path and ignored stores
        foreach (vt[i]) begin
            drive(vt[i].addr, vt[i].size, 32'(vt[i].data), vt[i].rd);
            check($sformatf("vec%0d_sel", i), 32'(sel_q), 32'(vt[i].exp_sel));
            check($sformatf("vec%0d_data", i), d_data, vt[i].exp_d);
        end

        // single byte 0x55: start + LSB-first data alternate 0,1,...
        drive(14'h3FF0, 2'b01, 32'h55, 1'b0);
        p = cyc;
        check("no_tx_on_push_edge", 32'(tx), 32'h1);
        idle(FL);
        pat = 10'b10_1010_1010;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("x55_bit%0d_first", i), 32'(tx_hist[p + 1 + DIV * i]), 32'(pat[i]));
            check($sformatf("x55_bit%0d_last", i), 32'(tx_hist[p + DIV + DIV * i]), 32'(pat[i]));
        end
        expect_drain(p, 1);

        // back-to-back: second start directly after first stop
        drive(14'h3FF0, 2'b11, 32'hA0, 1'b0);
        p = cyc;
        drive(14'h3FF1, 2'b10, 32'h0F, 1'b0);
        expect_drain(p, 2);
        check("b2b_stop_end", 32'(tx_hist[p + FL]), 32'h1);
        check("b2b_second_start", 32'(tx_hist[p + 1 + FL]), 32'h0);

        // overflow: one byte in flight, then 9 consecutive stores
        drive(14'h3FF0, 2'b01, 32'hC5, 1'b0);
        p = cyc;
        idle(1);
        for (int i = 0; i < 9; i++) drive(14'h3FF0, 2'b01, 32'(i * 37 + 3), 1'b0);
        drive(14'h3FF4, 2'b00, 32'h0, 1'b1);
        check("ovf_status", d_data, 32'h80D | PARW);
        drive(14'h3FF4, 2'b11, 32'h8, 1'b0);
        drive(14'h3FF4, 2'b00, 32'h0, 1'b1);
        check("ovf_cleared", d_data, 32'h805 | PARW);
        expect_drain(p, 9);
        check("ninth_frame_start", 32'(tx_hist[p + 1 + 8 * FL]), 32'h0);
        check("no_tenth_frame", 32'(tx_hist[p + 1 + 9 * FL]), 32'h1);

        // reset during data bit 3 with a second byte queued
        drive(14'h3FF0, 2'b01, 32'hF0, 1'b0);
        p = cyc;
        drive(14'h3FF0, 2'b01, 32'h3C, 1'b0);
        while (cyc < p + 1 + 4 * DIV + 1) idle(1);
        check("bit3_low", 32'(tx), 32'h0);
        #2 resetn = 1'b0;
        model_reset();
        #1 check("reset_midframe_tx", 32'(tx), 32'h1);
        tick();
        tick();
        resetn = 1'b1;
        drive(14'h3FF4, 2'b00, 32'h0, 1'b1);
        check("status_after_reset", d_data, IDLE_ST);
        idle(3 * FL);

`ifdef MMIO_UART_TX_PARITY_EN
        drive(14'h3FF0, 2'b01, 32'h07, 1'b0);
        p = cyc;
        idle(FL);
        check("parity_bit", 32'(tx_hist[p + 1 + 9 * DIV]), 32'h1);
        expect_drain(p, 1);
`endif

        // randomized traffic: heavy phase fills and overflows, light phase drains
        for (int i = 0; i < 1600; i++) begin
            d_addr  = ($urandom_range(0, 99) < 80) ? {10'h3FF, 4'($urandom)} : 14'($urandom);
            dw_size = ($urandom_range(0, 99) < (i < 800 ? 30 : 4)) ? 2'($urandom_range(1, 3)) : 2'b00;
            dw_data = $urandom;
            rd_en   = 1'($urandom);
            tick();
        end
        dw_size = 2'b00;
        rd_en = 1'b0;
        idle((DEPTH + 2) * FL);
        drive(14'h3FF4, 2'b11, 32'h8, 1'b0);
        drive(14'h3FF4, 2'b00, 32'h0, 1'b1);
        check("random_final_status", d_data, IDLE_ST);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the core's data-memory port, beside the 16 KB RAM. It decodes a small register window, accepts byte stores into a TX FIFO and answers status loads with the same one-cycle registered read latency as the RAM. It serialises the bytes as 8N1 frames on `tx`. It gives test programs a console and a pass/fail channel without adding anything to the core pipeline.

## Interface
- `BASE`, 14'h3FF0: byte address of the 16-byte register window. `BASE[3:0]` must be 0.
- `CLK_DIV`, 16: clock cycles per serial bit. Must be at least 2.
- `FIFO_DEPTH`, 8: number of TX FIFO entries. Must be a power of 2 and at least 2.
- `clk` in 1: single clock. All state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `d_addr` in 14: data byte address from the core.
- `dw_data` in 32: store data. Only bits [7:0] are used.
- `dw_size` in 2: store size. 00 means no store; 01, 10 and 11 mean a store of 8, 16 and 32 bits.
- `rd_en` in 1: load strobe for the current `d_addr`.
- `d_data` out 32: registered load data for this window.
- `sel_q` out 1: registered flag, high when `d_data` is valid for this window. The interconnect uses it as the read-data mux select.
- `tx` out 1: serial output. Idle level is high.

## Operation
- **Window decode**
  - `hit = (d_addr[13:4] == BASE[13:4])`.
  - Register offset is `d_addr[3:2]`. `d_addr[1:0]` is ignored.
- **Offset 0, TXDATA**
  - Store: if the FIFO is not full, push `dw_data[7:0]`.
  - Store while the FIFO is full: drop the byte and set `ovf`.
  - Load: returns 0.
- **Offset 1, STATUS** (read/clear)
  - Load fields:
    - bit0: `full`.
    - bit1: `empty`.
    - bit2: `busy` (FSM not in IDLE).
    - bit3: `ovf`.
    - bits[15:8]: FIFO count.
    - All other bits: 0.
  - Store with `dw_data[3]=1`: clears `ovf`. All other store bits are ignored.
- **Offsets 2 and 3**: stores are ignored and loads return 0.
- Stores and loads outside the window have no effect. `d_data` and `sel_q` are not updated for them except as stated under Timing.
- **FIFO**
  - Circular buffer with `log2(FIFO_DEPTH)`-bit read and write pointers, both wrapping modulo `FIFO_DEPTH`.
  - Separate count, width `log2(FIFO_DEPTH)+1`.
  - Full/empty are decided from the count as it was before the edge. A pop in the same cycle does not make room for a push.
  - A push and a pop in the same cycle leave the count unchanged.
- **TX FSM** (`bitcnt` is the bit index; the baud counter counts `CLK_DIV-1` down to 0)
  - **IDLE**: `tx=1`. If the FIFO is not empty: pop into the shift register, go to START and reload the baud counter.
  - **START**: `tx=0` for `CLK_DIV` cycles, then go to DATA with `bitcnt=0`.
  - **DATA**: `tx` = shift register bit 0, LSB first. Each bit lasts `CLK_DIV` cycles, after which the register shifts right. After bit 7, go to STOP (or to PARITY when configured).
  - **STOP**: `tx=1` for `CLK_DIV` cycles. Then, if the FIFO is not empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- `tx` is driven from a flop, so it never glitches.

## Timing
- **Reset values**:
  - `tx=1`, `d_data=0`, `sel_q=0`.
  - FSM in IDLE; FIFO empty with pointers and count at 0.
  - `ovf=0`, baud counter 0, shift register 0.
- **Reset asserted mid-frame**: `tx` goes high asynchronously and the frame and all FIFO contents are discarded.
- **Load latency**:
  - A load in cycle N with `rd_en & hit` gives `d_data` and `sel_q=1` after edge N+1.
  - `sel_q=0` after any edge without `rd_en & hit`.
  - STATUS returns the state as it was before edge N+1.
- **Store to empty FIFO with FSM in IDLE**:
  - The push happens at edge N.
  - The pop happens at edge N+1, and `tx` goes low after edge N+1.
  - A store to a non-empty FIFO simply queues the byte.
- **Frame length**: `10*CLK_DIV` cycles (`11*CLK_DIV` with parity).
- **Back-to-back bytes**: the next start bit follows the stop bit directly.
- **Simultaneous events**:
  - A TXDATA push and an FSM pop in the same cycle are both performed.
  - A TXDATA store that overflows in the same cycle as an `ovf` clear is impossible, because the two go to different offsets.

## Configuration
- Macro: `MMIO_UART_TX_PARITY_EN`.
- **Defined**:
  - A PARITY state sits between DATA and STOP.
  - `tx` = even parity (XOR of the 8 data bits) for `CLK_DIV` cycles.
  - Frame is `11*CLK_DIV` cycles.
  - STATUS bit4 reads 1.
- **Undefined**:
  - The PARITY state and its logic are absent.
  - Frame is `10*CLK_DIV` cycles.
  - STATUS bit4 reads 0.

## Test plan
- Single byte, `CLK_DIV=4`, store 0x55 to `BASE`:
  - `tx` falls 1 cycle after the push edge.
  - Sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level held 4 cycles.
  - `busy` drops after 40 cycles.
- Overflow, `FIFO_DEPTH=8`, 9 stores in consecutive cycles with the FSM busy:
  - STATUS reads `full=1`, `ovf=1`, count=8.
  - Only 8 bytes (plus the in-flight byte) are transmitted.
  - Storing 0x8 to `BASE+4` clears `ovf`.
- Back-to-back bytes, store 0xA0 then 0x0F:
  - The second start bit begins immediately after the first stop bit.
  - Total frame time is 80 cycles at `CLK_DIV=4`.
- Load path:
  - Load `BASE+4` with the FIFO empty and idle: after 1 cycle, `d_data=0x00000002`, `sel_q=1`.
  - Load `BASE`: returns 0.
  - Load `BASE+16` (outside the window): `sel_q=0`.
- Reset mid-frame: drop `resetn` during data bit 3 with 2 bytes queued.
  - `tx=1` immediately.
  - STATUS after release reads 0x00000002.
  - No further frames.
- With `MMIO_UART_TX_PARITY_EN`, store 0x07: the parity bit is 1, the frame is 44 cycles, and STATUS bit4 is 1.
